// File: rtl/sample_pkg.sv
// Shared definitions for the sampled-matrix read-side address generators.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package sample_pkg;

    localparam int NBAR   = 8;
    // Wide enough for the largest loop bound (1343).
    localparam int LOOP_W = 11;

    localparam logic [2:0] MODE_S  = 3'b000;  // S/S'  row-major
    localparam logic [2:0] MODE_EP = 3'b001;  // E'    8x8
    localparam logic [2:0] MODE_E  = 3'b010;  // E     column-major
    localparam logic [2:0] MODE_B  = 3'b100;  // B     linear
    localparam logic [2:0] MODE_BP = 3'b101;  // B'    paired halves

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Outer loop bound n-1 for a security level; 0 for the illegal level.
    function automatic logic [LOOP_W-1:0] level_loop(input logic [1:0] level);
        case (level)
            2'b01:   return 11'd1343;
            2'b10:   return 11'd975;
            2'b11:   return 11'd639;
            default: return 11'd0;
        endcase
    endfunction

    function automatic logic mode_legal(input logic [2:0] mode);
        case (mode)
            MODE_S, MODE_EP, MODE_E, MODE_B, MODE_BP: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sample_rd_lat_pipe.sv
// Tracks {valid, last} alongside memory read latency; synchronous flush clears it.
// Latency: exactly RD_LAT cycles from vld_i/last_i to vld_o/last_o.
// Backpressure: none; every entry emerges RD_LAT cycles later unless flushed.
// Ports: clk, rstn (async active-low); vld_i/last_i issue tag in; flush_i clears;
//        vld_o/last_o delayed tag; pend_o = a valid entry still sits before the output stage.
module sample_rd_lat_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic vld_i,
    input  logic last_i,
    input  logic flush_i,
    output logic vld_o,
    output logic last_o,
    output logic pend_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] last_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q  <= '0;
            last_q <= '0;
        end else if (flush_i) begin
            vld_q  <= '0;
            last_q <= '0;
        end else begin
            vld_q[0]  <= vld_i;
            last_q[0] <= last_i & vld_i;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                last_q[i] <= last_q[i-1];
            end
        end
    end

    assign vld_o  = vld_q[RD_LAT-1];
    assign last_o = last_q[RD_LAT-1];

    // The output stage is excluded: once only it is valid, the pipe is empty
    // on the following cycle.
    always_comb begin
        pend_o = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            pend_o = pend_o | vld_q[i];
        end
    end

endmodule

// File: rtl/sample_rd_agu.sv
// Read-side AGU: walks the sampled-matrix buffer (addr, bias) in MAC-consumption order.
// Latency: rd_en/rd_addr/rd_bias in the issue cycle; dout_valid/dout_last RD_LAT cycles later.
// Backpressure: take=0 stalls issue; nothing can stall returned data after issue.
// Ports: clk, rstn; start/abort/mode/level/take in; rd_en, rd_addr, rd_bias,
//        dout_valid, dout_last, busy, done, err out.
module sample_rd_agu
    import sample_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int AW     = 12
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          abort,
    input  logic [2:0]    mode,
    input  logic [1:0]    level,
    input  logic          take,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic [2:0]    rd_bias,
    output logic          dout_valid,
    output logic          dout_last,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t        state_q;
    logic [2:0]    mode_q;
    logic [1:0]    level_q;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    bias_q, bias_d;
    logic          done_q, err_q;
    logic [AW-1:0] loop_a;
    logic          at_end;
    logic          issue;
    logic          pend;

    assign loop_a = AW'(level_loop(level_q));
    assign issue  = (state_q == ST_RUN) && take && !abort;

    // Final index tuple of the latched traversal.
    always_comb begin
        at_end = 1'b1;
        case (mode_q)
            MODE_S, MODE_E: at_end = (addr_q == loop_a) && (bias_q == 3'd7);
            MODE_EP:        at_end = (addr_q == AW'(NBAR - 1)) && (bias_q == 3'd7);
            MODE_B:         at_end = (addr_q == loop_a);
            MODE_BP:        at_end = (addr_q[AW-1:1] == loop_a[AW-2:0]) && (bias_q == 3'd7);
            default:        at_end = 1'b1;
        endcase
    end

    // Inner-to-outer carry for each traversal order.
    always_comb begin
        addr_d = addr_q;
        bias_d = bias_q;
        case (mode_q)
            MODE_S, MODE_EP: begin
                if (bias_q == 3'd7) begin
                    bias_d = 3'd0;
                    addr_d = addr_q + AW'(1);
                end else begin
                    bias_d = bias_q + 3'd1;
                end
            end
            MODE_E: begin
                if (addr_q == loop_a) begin
                    addr_d = '0;
                    bias_d = bias_q + 3'd1;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            MODE_B: addr_d = addr_q + AW'(1);
            MODE_BP: begin
                // bias[0] innermost, then the even address, then bias[2:1].
                if (!bias_q[0]) begin
                    bias_d[0] = 1'b1;
                end else begin
                    bias_d[0] = 1'b0;
                    if (addr_q[AW-1:1] == loop_a[AW-2:0]) begin
                        addr_d      = '0;
                        bias_d[2:1] = bias_q[2:1] + 2'd1;
                    end else begin
                        addr_d = addr_q + AW'(2);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_S;
            level_q <= 2'b00;
            addr_q  <= '0;
            bias_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (abort) begin
                state_q <= ST_IDLE;
                addr_q  <= '0;
                bias_q  <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            if ((level == 2'b00) || !mode_legal(mode)) begin
                                err_q <= 1'b1;
                            end else begin
                                mode_q  <= mode;
                                level_q <= level;
                                addr_q  <= '0;
                                bias_q  <= '0;
                                state_q <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (take) begin
                            // The final tuple is held, not wrapped.
                            if (at_end) begin
                                state_q <= ST_DRAIN;
                            end else begin
                                addr_q <= addr_d;
                                bias_q <= bias_d;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (!pend) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                    ST_DONE: state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    sample_rd_lat_pipe #(.RD_LAT(RD_LAT)) u_lat_pipe (
        .clk     (clk),
        .rstn    (rstn),
        .vld_i   (issue),
        .last_i  (at_end),
        .flush_i (abort),
        .vld_o   (dout_valid),
        .last_o  (dout_last),
        .pend_o  (pend)
    );

    assign rd_en   = issue;
    assign rd_addr = addr_q;
    assign rd_bias = bias_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_sample_rd_agu.sv
// Bench for sample_rd_agu: two instances (RD_LAT=1 and RD_LAT=3) share stimulus.
// Latency: n/a.
// Backpressure: take is driven directly by the stimulus.
module tb_sample_rd_agu;

    localparam int AW = 12;

    logic          clk   = 1'b0;
    logic          rstn  = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          take  = 1'b0;
    logic [2:0]    mode  = 3'b000;
    logic [1:0]    level = 2'b00;

    logic          rd_en_w   [2];
    logic [AW-1:0] rd_addr_w [2];
    logic [2:0]    rd_bias_w [2];
    logic          dv_w      [2];
    logic          dl_w      [2];
    logic          busy_w    [2];
    logic          done_w    [2];
    logic          err_w     [2];

    sample_rd_agu #(.RD_LAT(1), .AW(AW)) dut0 (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .mode(mode),
        .level(level), .take(take), .rd_en(rd_en_w[0]), .rd_addr(rd_addr_w[0]),
        .rd_bias(rd_bias_w[0]), .dout_valid(dv_w[0]), .dout_last(dl_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0])
    );

    sample_rd_agu #(.RD_LAT(3), .AW(AW)) dut1 (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .mode(mode),
        .level(level), .take(take), .rd_en(rd_en_w[1]), .rd_addr(rd_addr_w[1]),
        .rd_bias(rd_bias_w[1]), .dout_valid(dv_w[1]), .dout_last(dl_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1])
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cycle %0d: got %0d expected %0d",
                     name, inst, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int exp_a[$];
    int exp_b[$];
    bit m_run    [2];
    int idx      [2];
    int done_at  [2];
    int err_at   [2];
    int abort_at [2];
    bit iss [2][65536];
    bit lst [2][65536];

    // Observation log of instance 0 and bookkeeping for literal checks.
    int cap_a[$];
    int cap_b[$];
    int cap_c[$];
    bit cap_l[$];
    int first_dv [2];
    int err_seen  = 0;
    int done_seen = 0;

    function automatic int loop_of(input logic [1:0] lv);
        case (lv)
            2'b01:   return 1343;
            2'b10:   return 975;
            2'b11:   return 639;
            default: return -1;
        endcase
    endfunction

    function automatic bit legal(input logic [2:0] m, input logic [1:0] lv);
        return (lv != 2'b00) && (m == 3'b000 || m == 3'b001 || m == 3'b010 ||
                                 m == 3'b100 || m == 3'b101);
    endfunction

    task automatic build(input logic [2:0] m, input logic [1:0] lv);
        int lp;
        lp = loop_of(lv);
        exp_a.delete();
        exp_b.delete();
        case (m)
            3'b000: for (int a = 0; a <= lp; a++)
                        for (int b = 0; b < 8; b++) begin exp_a.push_back(a); exp_b.push_back(b); end
            3'b001: for (int a = 0; a < 8; a++)
                        for (int b = 0; b < 8; b++) begin exp_a.push_back(a); exp_b.push_back(b); end
            3'b010: for (int b = 0; b < 8; b++)
                        for (int a = 0; a <= lp; a++) begin exp_a.push_back(a); exp_b.push_back(b); end
            3'b100: for (int a = 0; a <= lp; a++) begin exp_a.push_back(a); exp_b.push_back(0); end
            3'b101: for (int hi = 0; hi < 4; hi++)
                        for (int h = 0; h <= lp; h++)
                            for (int lo = 0; lo < 2; lo++) begin
                                exp_a.push_back(2 * h);
                                exp_b.push_back(2 * hi + lo);
                            end
            default: ;
        endcase
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_run[i]    = 1'b0;
            idx[i]      = 0;
            done_at[i]  = -1;
            err_at[i]   = -1;
            abort_at[i] = -1000000;
            first_dv[i] = -1;
        end
    end

    // Compare process: every cycle, both instances, sampled on the falling edge.
    always @(negedge clk) begin
        int  lat, s;
        bit  eb, er, ev, el, last;
        for (int i = 0; i < 2; i++) begin
            lat = (i == 0) ? 1 : 3;
            if (!rstn) begin
                check("rst_rd_en", i, rd_en_w[i], 0);
                check("rst_addr",  i, rd_addr_w[i], 0);
                check("rst_bias",  i, rd_bias_w[i], 0);
                check("rst_dv",    i, dv_w[i], 0);
                check("rst_dl",    i, dl_w[i], 0);
                check("rst_busy",  i, busy_w[i], 0);
                check("rst_done",  i, done_w[i], 0);
                check("rst_err",   i, err_w[i], 0);
                m_run[i]    = 1'b0;
                done_at[i]  = -1;
                err_at[i]   = -1;
                abort_at[i] = cyc;
            end else begin
                eb = m_run[i] || (cyc <= done_at[i]);
                er = m_run[i] && take && !abort;
                s  = cyc - lat;
                ev = (s >= 0) && (s < 65536) && iss[i][s] && !(abort_at[i] >= s);
                el = ev && lst[i][s];
                check("rd_en", i, rd_en_w[i], er);
                check("busy",  i, busy_w[i], eb);
                check("done",  i, done_w[i], cyc == done_at[i]);
                check("err",   i, err_w[i], cyc == err_at[i]);
                check("dout_valid", i, dv_w[i], ev);
                check("dout_last",  i, dl_w[i], el);
                if (dv_w[i] && first_dv[i] < 0) first_dv[i] = cyc;
                if (i == 0 && rd_en_w[0]) begin
                    cap_a.push_back(int'(rd_addr_w[0]));
                    cap_b.push_back(int'(rd_bias_w[0]));
                    cap_c.push_back(cyc);
                    cap_l.push_back(1'b0);
                end
                if (i == 0 && err_w[0])  err_seen++;
                if (i == 0 && done_w[0]) done_seen++;
                if (er) begin
                    last = 1'b1;
                    if (idx[i] < exp_a.size()) begin
                        check("rd_addr", i, rd_addr_w[i], exp_a[idx[i]]);
                        check("rd_bias", i, rd_bias_w[i], exp_b[idx[i]]);
                        last = (idx[i] == exp_a.size() - 1);
                    end
                    if (cyc < 65536) begin
                        iss[i][cyc] = 1'b1;
                        lst[i][cyc] = last;
                    end
                    if (i == 0 && cap_l.size() > 0) cap_l[cap_l.size()-1] = last;
                    idx[i]++;
                    if (last) begin
                        m_run[i]   = 1'b0;
                        done_at[i] = cyc + lat + 1;
                    end
                end
                if (abort) begin
                    abort_at[i] = cyc;
                    if (eb) begin
                        m_run[i]   = 1'b0;
                        done_at[i] = -1;
                    end
                end else if (start && !eb) begin
                    if (legal(mode, level)) begin
                        build(mode, level);
                        m_run[i] = 1'b1;
                        idx[i]   = 0;
                    end else begin
                        err_at[i] = cyc + 1;
                    end
                end
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic traverse(input logic [2:0] m, input logic [1:0] lv, input bit toggle,
                            input int abort_n, input bit mid_start);
        bit fin;
        bit aborted;
        fin     = 1'b0;
        aborted = 1'b0;
        cap_a.delete(); cap_b.delete(); cap_c.delete(); cap_l.delete();
        first_dv[0] = -1;
        first_dv[1] = -1;
        done_seen   = 0;
        @(posedge clk); #1;
        mode  = m;
        level = lv;
        start = 1'b1;
        take  = 1'b0;
        for (int k = 0; k < 30000 && !fin; k++) begin
            @(posedge clk); #1;
            start = mid_start && (k == 50);
            take  = toggle ? (k % 2 == 0) : 1'b1;
            abort = 1'b0;
            if (abort_n >= 0 && !aborted && cap_a.size() == abort_n) begin
                abort   = 1'b1;
                aborted = 1'b1;
            end
            @(negedge clk);
            if (!busy_w[0] && !busy_w[1]) fin = 1'b1;
        end
        check("traversal_finished", 0, fin, 1);
        @(posedge clk); #1;
        take  = 1'b0;
        abort = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("lit_idle_busy", 0, busy_w[0], 0);

        // S/S' level 11, take held
        traverse(3'b000, 2'b11, 1'b0, -1, 1'b0);
        check("lit_s_count", 0, cap_a.size(), 5120);
        check("lit_s_b1",    0, cap_b[1], 1);
        check("lit_s_a8",    0, cap_a[8], 1);
        check("lit_s_last_a", 0, cap_a[5119], 639);
        check("lit_s_last_b", 0, cap_b[5119], 7);
        check("lit_s_dv_lag", 0, first_dv[0] - cap_c[0], 1);
        check("lit_s_done",   0, done_seen, 1);

        // E level 01, take toggling
        traverse(3'b010, 2'b01, 1'b1, -1, 1'b0);
        check("lit_e_count", 0, cap_a.size(), 10752);
        check("lit_e_span",  0, cap_c[10751] - cap_c[0] + 1, 21503);
        check("lit_e_1343",  0, cap_a[1343], 1343);
        check("lit_e_wrap_a", 0, cap_a[1344], 0);
        check("lit_e_wrap_b", 0, cap_b[1344], 1);

        // B' level 10
        traverse(3'b101, 2'b10, 1'b0, -1, 1'b0);
        check("lit_bp_a2", 0, cap_a[2], 2);
        check("lit_bp_b3", 0, cap_b[3], 1);
        check("lit_bp_a4", 0, cap_a[4], 4);
        check("lit_bp_pre_a", 0, cap_a[1951], 1950);
        check("lit_bp_pre_b", 0, cap_b[1951], 1);
        check("lit_bp_wrap_a", 0, cap_a[1952], 0);
        check("lit_bp_wrap_b", 0, cap_b[1952], 2);
        check("lit_bp_last_a", 0, cap_a[cap_a.size()-1], 1950);
        check("lit_bp_last_b", 0, cap_b[cap_b.size()-1], 7);
        check("lit_bp_last_tag", 0, cap_l[cap_l.size()-1], 1);

        // E' level 01
        traverse(3'b001, 2'b01, 1'b0, -1, 1'b0);
        check("lit_ep_count",  0, cap_a.size(), 64);
        check("lit_ep_last_a", 0, cap_a[63], 7);
        check("lit_ep_last_b", 0, cap_b[63], 7);
        check("lit_ep_done",   0, done_seen, 1);

        // Rejected starts
        err_seen = 0;
        traverse(3'b000, 2'b00, 1'b0, -1, 1'b0);
        check("lit_err_level", 0, err_seen, 1);
        traverse(3'b011, 2'b11, 1'b0, -1, 1'b0);
        check("lit_err_mode", 0, err_seen, 2);

        // abort together with start in IDLE
        @(posedge clk); #1;
        mode = 3'b000; level = 2'b11; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("lit_abort_start_busy", 0, busy_w[0], 0);
        check("lit_abort_start_err",  0, err_w[0], 0);

        // abort at issue 100
        traverse(3'b000, 2'b11, 1'b0, 100, 1'b0);
        check("lit_abort_count", 0, cap_a.size(), 100);
        check("lit_abort_done",  0, done_seen, 0);

        // B level 11, stray start mid-run; RD_LAT=3 lag on instance 1
        traverse(3'b100, 2'b11, 1'b0, -1, 1'b1);
        check("lit_b_count",  0, cap_a.size(), 640);
        check("lit_b_last_a", 0, cap_a[639], 639);
        check("lit_b_lag3",   1, first_dv[1] - cap_c[0], 3);

        // Reset in the middle of a traversal
        @(posedge clk); #1;
        mode = 3'b000; level = 2'b11; start = 1'b1; take = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1 rstn = 1'b0;
        @(negedge clk);
        check("lit_rst_busy",  0, busy_w[0], 0);
        check("lit_rst_dv3",   1, dv_w[1], 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        take = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        traverse(3'b001, 2'b11, 1'b0, -1, 1'b0);
        check("lit_post_rst_count", 0, cap_a.size(), 64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_rd_agu.md
Name: sample_rd_agu

Overview:
- Read-side address generator for the sampled-matrix buffer that the hash engine fills: S/S', E, E', B, B'.
- The write-side AGU places entries at (addr, bias): addr is the row/word index 0..n-1 and bias is the bank/column 0..7 (nbar=8). This block walks the same storage in the order the matrix-arithmetic unit consumes it.
- Issues memory read strobes under a consumer handshake and returns a delayed valid/last tag aligned with memory read latency.
- Sits between the sample memory banks and the MAC array.

Parameters:
- RD_LAT, 1, memory read latency in cycles (1..4) from rd_en to data at bank output.
- AW, 12, address width.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  begin a traversal; sampled only in IDLE
- abort  in  1  synchronous cancel; highest priority after reset
- mode  in  3  traversal select, latched on start
- level  in  2  security level, latched on start: 01→n=1344, 10→n=976, 11→n=640, 00 illegal
- take  in  1  consumer ready; one read issued per cycle with take=1 in RUN
- rd_en  out  1  memory read strobe = (state==RUN) & take
- rd_addr  out  AW  registered read address
- rd_bias  out  3  registered bank select
- dout_valid  out  1  rd_en delayed RD_LAT cycles
- dout_last  out  1  marks the final element, aligned with dout_valid
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at traversal completion
- err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, latency pipeline cleared.
- loop = n-1: 1343, 975, 639 by level.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start with level=00 or a mode outside {000,001,010,100,101}: err=1 for one cycle, stay IDLE.
  - Otherwise latch mode and level, set addr=0 and bias=0, go to RUN next cycle.
- RUN: each cycle with take=1, present current (rd_addr, rd_bias) with rd_en=1, then advance. take=0 holds everything; no rd_en.
- Traversal orders, inner index first:
  - 000 S/S' (row-major): bias 0..7 inner, addr 0..loop outer. Total 8(loop+1).
  - 001 E' (8x8): bias 0..7 inner, addr 0..7 outer. Total 64. level is still checked for legality.
  - 010 E (column-major): addr 0..loop inner, bias 0..7 outer. Total 8(loop+1).
  - 100 B (linear): addr 0..loop, bias fixed 0. Total loop+1.
  - 101 B' (paired halves):
    - bias[0] toggles innermost.
    - Then addr[AW-1:1] steps 0..loop, with addr[0] held 0.
    - Then bias[2:1] steps 0..3 outermost.
    - Total 8(loop+1).
- Last issue: the issue at the final index tuple carries last=1 into the pipeline. State goes to DRAIN next cycle; addr and bias hold their final values (no wrap).
- DRAIN: wait until the pipeline holds no valid entries (RD_LAT cycles after the last issue), then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Latency: dout_valid and dout_last equal rd_en and the last tag delayed exactly RD_LAT cycles. There is no backpressure after issue; the consumer must sink all returned data.
- start while busy: ignored, no err.
- abort in any non-IDLE state:
  - Next cycle IDLE, pipeline valid bits cleared, counters 0.
  - No done pulse; rd_en is 0 in the abort cycle.
- abort and start together in IDLE: abort wins, start ignored.
- Reset mid-traversal: immediate return to the reset values.
- Arithmetic: counters are unsigned. The compare is against loop, not against width overflow. The 3-bit bias wraps 7→0 only as part of the inner-to-outer carry.

Decomposition:
- Shared package sample_pkg holds:
  - mode encodings MODE_S=3'b000, MODE_EP=3'b001, MODE_E=3'b010, MODE_B=3'b100, MODE_BP=3'b101;
  - a level→loop function (values 1343, 975, 639);
  - NBAR=8 and the FSM state typedef.
- One sub-module, sample_rd_lat_pipe: an RD_LAT-deep shift register of {valid, last} with synchronous flush. It is reusable by other read-side AGUs.

Test Plan:
- Reset, then mode=000, level=11, start, take held 1 → 5120 rd_en cycles.
  - Issue order (0,0),(0,1)..(0,7),(1,0)...; the final issue is (639,7) with last=1.
  - With RD_LAT=1, dout_last follows one cycle later; done pulses 1 cycle after DRAIN.
- mode=010, level=01, take toggled 1/0 every cycle → 10752 issues over 21503 cycles.
  - Sequence (0,0)..(1343,0),(0,1)...; no issue when take=0.
- mode=101, level=10 → first issues (addr,bias) = (0,0),(0,1),(2,0),(2,1),(4,0).
  - After (1950,1) comes (0,2); final (1950,7) carries last.
- mode=001, level=01 → exactly 64 issues, final (7,7); done asserted 1 cycle.
- Negative/abort cases:
  - start with level=00 → err pulse, busy stays 0.
  - start with mode=011 → err.
  - abort at issue 100 of mode 000 → busy 0 next cycle, no further dout_valid, no done.
- RD_LAT=3 build, mode=100, level=11 → dout_valid trails rd_en by 3 cycles.
  - 640 beats, last on addr 639.
  - start pulsed mid-RUN has no effect.
